// File: rtl/lcd_pkg.sv
// Shared constants and types for the character-LCD time-line path.
package lcd_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COLON = 8'h3A;

  localparam int unsigned LINE2_BASE = 16;
  localparam int unsigned LINE_LEN   = 16;

  // One time field is a byte: tens digit in the upper nibble, ones in the lower.
  localparam int unsigned FIELD_W = 8;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_field_t;

  typedef enum logic [1:0] {
    SLOT_TENS = 2'd0,
    SLOT_ONES = 2'd1,
    SLOT_SEP  = 2'd2
  } slot_e;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [2:0] group;
    slot_e      slot;
  } pos_t;

  // Maps a line-2 offset to (group, slot) = (p/3, p%3) without a divider.
  function automatic pos_t decode_pos(input logic [3:0] p);
    pos_t d;
    d.group = '0;
    d.slot  = SLOT_TENS;
    case (p)
      4'd0:  begin d.group = 3'd0; d.slot = SLOT_TENS; end
      4'd1:  begin d.group = 3'd0; d.slot = SLOT_ONES; end
      4'd2:  begin d.group = 3'd0; d.slot = SLOT_SEP;  end
      4'd3:  begin d.group = 3'd1; d.slot = SLOT_TENS; end
      4'd4:  begin d.group = 3'd1; d.slot = SLOT_ONES; end
      4'd5:  begin d.group = 3'd1; d.slot = SLOT_SEP;  end
      4'd6:  begin d.group = 3'd2; d.slot = SLOT_TENS; end
      4'd7:  begin d.group = 3'd2; d.slot = SLOT_ONES; end
      4'd8:  begin d.group = 3'd2; d.slot = SLOT_SEP;  end
      4'd9:  begin d.group = 3'd3; d.slot = SLOT_TENS; end
      4'd10: begin d.group = 3'd3; d.slot = SLOT_ONES; end
      4'd11: begin d.group = 3'd3; d.slot = SLOT_SEP;  end
      4'd12: begin d.group = 3'd4; d.slot = SLOT_TENS; end
      4'd13: begin d.group = 3'd4; d.slot = SLOT_ONES; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lcd_blink_timer.sv
// Free-running blink divider: phase toggles every BLINK_DIV clock cycles.
module lcd_blink_timer
  import lcd_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic   clk,
  input  logic   rst,
  output phase_e phase
);

  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..BLINK_DIV-1 and flip the phase on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PHASE_VISIBLE;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= (phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_time_line_fmt.sv
// Character generator for the 2x16 LCD: line 1 blank, line 2 shows BCD time
// fields from a per-frame snapshot, with edit blink, invalid-digit glyph and
// optional leading-zero blanking. One registered ASCII byte per request.
module lcd_time_line_fmt
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 3,
  parameter int unsigned START_COL  = 0,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned LZB        = 0,
  parameter logic [7:0]  SEP_CHAR   = 8'h3A
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [4:0]                index,
  input  logic [8*NUM_FIELDS-1:0]   fields_bcd,
  input  logic [2:0]                edit_sel,
  output logic                      valid,
  output logic [7:0]                out
);

  localparam int unsigned SPAN        = 3 * NUM_FIELDS - 1;
  localparam int unsigned LINE2_START = LINE2_BASE + START_COL;
  localparam logic [2:0]  LAST_FIELD  = 3'(NUM_FIELDS - 1);

  phase_e                    phase;
  logic [8*NUM_FIELDS-1:0]   snap_fields;
  logic [2:0]                snap_edit;
  phase_e                    snap_phase;

  logic       in_line2;
  logic [4:0] rel;
  pos_t       pos;
  logic [2:0] fsel;
  bcd_field_t fld;
  logic [3:0] nib;
  logic [7:0] ch;

  lcd_blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .phase(phase)
  );

  // Latch the time value, edit selection and blink phase at the start of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_fields <= '0;
      snap_edit   <= '0;
      snap_phase  <= PHASE_VISIBLE;
    end else if (req && (index == 5'd0)) begin
      snap_fields <= fields_bcd;
      snap_edit   <= edit_sel;
      snap_phase  <= phase;
    end
  end

  // Render the character for the current index from the snapshot.
  // Index 0 is on line 1 and always a space, so rendering it from the
  // pre-latch snapshot is indistinguishable from using the new one.
  always_comb begin
    rel      = index - 5'(LINE2_START);
    in_line2 = ({1'b0, index} >= 6'(LINE2_START)) && (rel < 5'(SPAN));
    pos      = decode_pos(rel[3:0]);
    fsel     = LAST_FIELD - pos.group;
    fld      = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      if (fsel == 3'(k)) fld = snap_fields[FIELD_W*k +: FIELD_W];
    end
    nib = (pos.slot == SLOT_TENS) ? fld.tens : fld.ones;
    ch  = CH_SPACE;
    if (in_line2) begin
      if (pos.slot == SLOT_SEP)
        ch = SEP_CHAR;
      else if ((snap_phase == PHASE_HIDDEN) && (snap_edit == fsel + 3'd1))
        ch = CH_SPACE;
      else if (nib > 4'd9)
        ch = CH_DASH;
      else if ((LZB != 0) && (fsel == LAST_FIELD) && (pos.slot == SLOT_TENS) && (nib == 4'd0))
        ch = CH_SPACE;
      else
        ch = CH_ZERO + {4'h0, nib};
    end
  end

  // Register the response; out holds its value when there is no request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= 8'h00;
      valid <= 1'b0;
    end else begin
      valid <= req;
      if (req) out <= ch;
    end
  end

endmodule
